// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant state encoding
// and the default stall limit used by the optional watchdog.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Wide enough for the largest legal stall limit (65535).
  localparam int WD_COUNT_WIDTH = 16;

endpackage

// File: rtl/wb_stall_watchdog.sv
// Stall watchdog for the arbiter: counts stalled strobe cycles, flags a timeout
// and holds an abort until the granted master ends its bus cycle.
module wb_stall_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic grant_change,
  input  logic gnt_cyc,
  output logic timeout,
  output logic abort
);

  localparam logic [WD_COUNT_WIDTH-1:0] LIMIT = WD_COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WD_COUNT_WIDTH-1:0] count_reg;
  logic                      abort_reg;

  // Count holds the number of consecutive stalled cycles already seen, so the
  // timeout fires during the TIMEOUT_CYCLES-th stalled cycle.
  assign timeout = stall && !abort_reg && (count_reg == LIMIT);
  assign abort   = abort_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      abort_reg <= 1'b0;
    end else begin
      if (grant_change || !stall) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end

      if (!gnt_cyc) begin
        abort_reg <= 1'b0;
      end else if (timeout) begin
        abort_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter sharing one slave port; grants are held
// for a whole cyc. Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [ADDR_WIDTH-1:0]     m0_adr,
  input  logic [DATA_WIDTH-1:0]     m0_dat_w,
  input  logic [DATA_WIDTH/8-1:0]   m0_sel,
  input  logic                      m0_we,
  input  logic                      m0_cyc,
  input  logic                      m0_stb,
  output logic [DATA_WIDTH-1:0]     m0_dat_r,
  output logic                      m0_ack,
  output logic                      m0_err,

  input  logic [ADDR_WIDTH-1:0]     m1_adr,
  input  logic [DATA_WIDTH-1:0]     m1_dat_w,
  input  logic [DATA_WIDTH/8-1:0]   m1_sel,
  input  logic                      m1_we,
  input  logic                      m1_cyc,
  input  logic                      m1_stb,
  output logic [DATA_WIDTH-1:0]     m1_dat_r,
  output logic                      m1_ack,
  output logic                      m1_err,

  output logic [ADDR_WIDTH-1:0]     s_adr,
  output logic [DATA_WIDTH-1:0]     s_dat_w,
  output logic [DATA_WIDTH/8-1:0]   s_sel,
  output logic                      s_we,
  output logic                      s_cyc,
  output logic                      s_stb,
  input  logic [DATA_WIDTH-1:0]     s_dat_r,
  input  logic                      s_ack,
  input  logic                      s_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES must be within 2..65535");
  end

  arb_state_e state_reg, state_next;
  logic       prio_reg, prio_next;

  logic       abort;
  logic       wd_timeout;
  logic       bus_cyc;
  logic       bus_stb;
  logic       gnt0;
  logic       gnt1;

  assign gnt0 = (state_reg == ARB_GNT0);
  assign gnt1 = (state_reg == ARB_GNT1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
      prio_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    prio_next  = prio_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (m0_cyc && (!m1_cyc || !prio_reg)) begin
          state_next = ARB_GNT0;
        end else if (m1_cyc) begin
          state_next = ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!m0_cyc) begin
          state_next = m1_cyc ? ARB_GNT1 : ARB_IDLE;
        end
      end
      ARB_GNT1: begin
        if (!m1_cyc) begin
          state_next = m0_cyc ? ARB_GNT0 : ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase

    // Every fresh grant hands the next tie to the other master.
    if (state_next != state_reg) begin
      if (state_next == ARB_GNT0) begin
        prio_next = 1'b1;
      end else if (state_next == ARB_GNT1) begin
        prio_next = 1'b0;
      end
    end
  end

  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    bus_cyc = 1'b0;
    bus_stb = 1'b0;
    case (state_reg)
      ARB_GNT0: begin
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        s_sel   = m0_sel;
        s_we    = m0_we;
        bus_cyc = m0_cyc & ~abort;
        bus_stb = m0_stb & m0_cyc & ~abort;
      end
      ARB_GNT1: begin
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
        s_we    = m1_we;
        bus_cyc = m1_cyc & ~abort;
        bus_stb = m1_stb & m1_cyc & ~abort;
      end
      default: ;
    endcase
  end

  assign s_cyc    = bus_cyc;
  assign s_stb    = bus_stb;
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  // Gating with bus_cyc also discards a late slave ack once abort is set.
  assign m0_ack = gnt0 & s_ack & bus_cyc;
  assign m1_ack = gnt1 & s_ack & bus_cyc;
  assign m0_err = gnt0 & ((s_err & bus_cyc) | wd_timeout);
  assign m1_err = gnt1 & ((s_err & bus_cyc) | wd_timeout);

`ifdef WB_ARB_TIMEOUT_EN
  logic gnt_cyc;
  logic stall;

  assign gnt_cyc = (gnt0 & m0_cyc) | (gnt1 & m1_cyc);
  assign stall   = bus_cyc & bus_stb & ~s_ack & ~s_err;

  wb_stall_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .grant_change (state_next != state_reg),
    .gnt_cyc      (gnt_cyc),
    .timeout      (wd_timeout),
    .abort        (abort)
  );
`else
  assign abort      = 1'b0;
  assign wd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: random two-master traffic scored against
// a grant/ownership model, followed by directed reset, tie and stall scenarios.
module tb_wb_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          we;
  } req_t;

  typedef struct {
    int            mid;
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr   [2];
  logic [DW-1:0] m_dat_w [2];
  logic [SW-1:0] m_sel   [2];
  logic          m_we    [2];
  logic          m_cyc   [2];
  logic          m_stb   [2];
  logic [DW-1:0] m_dat_r [2];
  logic          m_ack   [2];
  logic          m_err   [2];

  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w;
  logic [SW-1:0] s_sel;
  logic          s_we, s_cyc, s_stb;
  logic [DW-1:0] s_dat_r;
  logic          s_ack, s_err;

  wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_adr(m_adr[0]), .m0_dat_w(m_dat_w[0]), .m0_sel(m_sel[0]), .m0_we(m_we[0]),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_dat_r(m_dat_r[0]), .m0_ack(m_ack[0]), .m0_err(m_err[0]),
    .m1_adr(m_adr[1]), .m1_dat_w(m_dat_w[1]), .m1_sel(m_sel[1]), .m1_we(m_we[1]),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_dat_r(m_dat_r[1]), .m1_ack(m_ack[1]), .m1_err(m_err[1]),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the slave port and who wins the next tie.
  int owner = -1;
  bit prio = 1'b0;
  bit mon_en = 1'b0;
  bit run_new = 1'b1;
  bit first_beat = 1'b1;
  int beats [2];
  int idle [2];
  bit done_seen [2];
  int stall_cnt = 0;

  req_t exp_q0 [$];
  req_t exp_q1 [$];
  rsp_t rsp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Grant rules: free port goes to the sole requester or the prio winner; an owner
  // keeps it while its cyc is high, then hands it straight to a waiting master.
  task automatic model_update();
    if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) owner = prio ? 1 : 0;
      else if (m_cyc[0]) owner = 0;
      else if (m_cyc[1]) owner = 1;
      if (owner >= 0) prio = (owner == 0);
    end else if (!m_cyc[owner]) begin
      if (m_cyc[1-owner]) begin
        owner = 1 - owner;
        prio = (owner == 0);
      end else begin
        owner = -1;
      end
    end
  endtask

  task automatic new_beat(input int m);
    req_t q;
    if (first_beat && m == 0) begin
      q.adr = 32'h4000_0010; q.dat = 32'h0000_BEEF; q.sel = 4'hF; q.we = 1'b1;
      first_beat = 1'b0;
    end else begin
      q.adr = $urandom; q.dat = $urandom; q.sel = SW'($urandom); q.we = 1'($urandom);
    end
    m_adr[m] = q.adr; m_dat_w[m] = q.dat; m_sel[m] = q.sel; m_we[m] = q.we;
    m_stb[m] = 1'b1;
    if (m == 0) exp_q0.push_back(q);
    else exp_q1.push_back(q);
  endtask

  task automatic drive_masters();
    for (int m = 0; m < 2; m++) begin
      if (m_cyc[m]) begin
        if (m_stb[m] && done_seen[m]) begin
          beats[m]--;
          if (beats[m] == 0) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
            idle[m] = $urandom_range(0, 3);
          end else begin
            new_beat(m);
          end
        end
      end else begin
        m_adr[m] = $urandom; m_dat_w[m] = $urandom;
        if (idle[m] > 0) begin
          idle[m]--;
        end else if (run_new) begin
          m_cyc[m] = 1'b1;
          beats[m] = $urandom_range(1, 3);
          new_beat(m);
        end
      end
    end
  endtask

  task automatic drive_slave();
    rsp_t r;
    int   sel_r;
    s_dat_r = $urandom;
    s_ack = 1'b0; s_err = 1'b0;
    if (s_cyc && s_stb) begin
      stall_cnt++;
      sel_r = $urandom_range(0, 9);
      if (stall_cnt >= 8 || sel_r < 6) begin
        s_ack = (sel_r != 1);
        s_err = (sel_r <= 1);
        r.mid = owner; r.ack = s_ack; r.err = s_err; r.dat = s_dat_r;
        rsp_q.push_back(r);
        stall_cnt = 0;
      end
    end else begin
      stall_cnt = 0;
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_update();
    #1 drive_masters();
    #1 drive_slave();
    #1;
    for (int m = 0; m < 2; m++) done_seen[m] = m_ack[m] | m_err[m];
  endtask

  // Monitor: compares the bus against the model and pops the scoreboard whenever
  // a beat completes on the slave side or a response reaches a master.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   es_cyc, es_stb;
      rsp_t r;
      req_t q;
      es_cyc = (owner >= 0) && m_cyc[owner];
      es_stb = es_cyc && m_stb[owner];
      chk("s_cyc", 64'(s_cyc), 64'(es_cyc));
      chk("s_stb", 64'(s_stb), 64'(es_stb));
      chk("dat_r passthrough", {m_dat_r[0], m_dat_r[1]}, {s_dat_r, s_dat_r});
      if (es_stb && (s_ack || s_err)) begin
        if ((owner == 0 && exp_q0.size() == 0) || (owner == 1 && exp_q1.size() == 0)) begin
          fail_now("beat queue empty", 0, 1);
        end else begin
          q = (owner == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk("s_adr", 64'(s_adr), 64'(q.adr));
          chk("s_dat_w", 64'(s_dat_w), 64'(q.dat));
          chk("s_sel/we", 64'({s_sel, s_we}), 64'({q.sel, q.we}));
        end
      end
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        if (r.mid < 0) begin
          fail_now("response owner", r.mid, 0);
        end else begin
          chk("ack/err granted", 64'({m_ack[r.mid], m_err[r.mid]}), 64'({r.ack, r.err}));
          chk("ack/err other", 64'({m_ack[1-r.mid], m_err[1-r.mid]}), 64'(0));
          chk("read data", 64'(m_dat_r[r.mid]), 64'(r.dat));
        end
      end else begin
        chk("no response", 64'({m_ack[0], m_ack[1], m_err[0], m_err[1]}), 64'(0));
      end
    end
  end

  initial begin
    int k;
    for (int m = 0; m < 2; m++) begin
      m_adr[m] = '0; m_dat_w[m] = '0; m_sel[m] = '0; m_we[m] = 1'b0;
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
      beats[m] = 0; idle[m] = 0; done_seen[m] = 1'b0;
    end
    s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;

    #12;
    chk("reset s_cyc/s_stb", 64'({s_cyc, s_stb}), 64'(0));
    chk("reset s_adr", 64'(s_adr), 64'(0));
    chk("reset acks", 64'({m_ack[0], m_ack[1], m_err[0], m_err[1]}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // Random traffic; both masters start together so the first grant is a tie.
    for (int c = 0; c < 400; c++) run_cycle();
    run_new = 1'b0;
    k = 0;
    while ((m_cyc[0] || m_cyc[1]) && k < 200) begin
      run_cycle();
      k++;
    end
    if (m_cyc[0] || m_cyc[1]) fail_now("drain timeout", k, 200);
    #6;
    mon_en = 1'b0;
    chk("beat queue 0 drained", 64'(exp_q0.size()), 64'(0));
    chk("beat queue 1 drained", 64'(exp_q1.size()), 64'(0));
    chk("response queue drained", 64'(rsp_q.size()), 64'(0));

    // Reset in the middle of a stalled m0 cycle.
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = 32'h0;
    m_adr[0] = 32'h1000_0004; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("stalled m0 granted", 64'(s_cyc), 64'(1));
    reset = 1'b1;
    #1;
    chk("async reset s_cyc/s_stb", 64'({s_cyc, s_stb}), 64'(0));
    m_adr[1] = 32'h2000_0008; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(posedge clk); #2;
    chk("held reset s_cyc", 64'(s_cyc), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    #1 chk("idle after reset", 64'(s_cyc), 64'(0));
    @(posedge clk); #2;
    chk("post-reset tie to m0", 64'({s_cyc, s_adr}), 64'({1'b1, m_adr[0]}));
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1 chk("s_cyc drops with m0_cyc", 64'(s_cyc), 64'(0));
    @(posedge clk); #2;
    chk("back-to-back m1", 64'({s_cyc, s_adr}), 64'({1'b1, m_adr[1]}));
    s_ack = 1'b1; s_dat_r = 32'h1234_5678;
    #1 chk("read ack routing", 64'({m_ack[1], m_ack[0], m_err[0], m_err[1]}), 64'(4'b1000));
    chk("read data m1/m0", {m_dat_r[1], m_dat_r[0]}, {32'h1234_5678, 32'h1234_5678});
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
    @(posedge clk); #2;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk); #2;
    chk("solo m0 grant", 64'({s_cyc, s_adr}), 64'({1'b1, m_adr[0]}));
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(posedge clk); #2;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(posedge clk); #2;
    chk("next tie to m1", 64'({s_cyc, s_adr}), 64'({1'b1, m_adr[1]}));
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    @(posedge clk); #2;

    // Slave never responds to m0 while m1 waits.
    m_adr[0] = 32'h3000_0000; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk); #2;
    m_adr[1] = 32'h5000_0040; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int s = 1; s <= TO + 1; s++) begin
      chk($sformatf("timeout err cycle %0d", s), 64'({m_err[0], m_err[1]}), 64'({s == TO, 1'b0}));
      chk($sformatf("timeout s_cyc cycle %0d", s), 64'(s_cyc), 64'(s <= TO));
      if (s <= TO) begin
        @(posedge clk); #2;
      end
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(posedge clk); #2;
    chk("m1 granted after abort", 64'({s_cyc, s_adr}), 64'({1'b1, m_adr[1]}));
`else
    for (int s = 1; s <= TO + 4; s++) begin
      chk($sformatf("no watchdog cycle %0d", s), 64'({s_cyc, m_err[0], m_err[1], m_ack[1]}), 64'(4'b1000));
      @(posedge clk); #2;
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(posedge clk); #2;
    chk("m1 granted after m0 release", 64'({s_cyc, s_adr}), 64'({1'b1, m_adr[1]}));
`endif
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    @(posedge clk); #2;
    chk("final idle", 64'({s_cyc, s_stb}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
